// File: rtl/audio_pkg.sv
// Shared types and constants for the audio receive path.
package audio_pkg;
  localparam int DATA_W = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} rx_state_t;
endpackage

// File: rtl/audio_pin_sync.sv
// Multi-flop synchronizer for one codec pin plus a rising-edge strobe on the synced value.
module audio_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= pin_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/i2s_audio_rx.sv
// I2S ADC receiver: oversampled pins, word capture FSM, L/R pair handshake and peak meter.
module i2s_audio_rx
  import audio_pkg::*;
#(
  parameter int DATA_W      = audio_pkg::DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int DECAY_SHIFT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              aud_bclk,
  input  logic              aud_adclrck,
  input  logic              aud_adcdat,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              clear_overrun,
  output logic [DATA_W-2:0] peak
);
  localparam int CW = $clog2(DATA_W);
  localparam int PW = DATA_W - 1;

  logic [2:0] pin_s, pin_rise;

  // All three pins share one delay so data stays aligned with BCLK.
  audio_pin_sync #(.STAGES(SYNC_STAGES)) u_sync [2:0] (
    .clk   (clk),
    .reset (reset),
    .pin_i ({aud_adcdat, aud_adclrck, aud_bclk}),
    .sync_o(pin_s),
    .rise_o(pin_rise)
  );

  logic unused_rise;
  assign unused_rise = ^pin_rise[2:1];

  logic bit_tick, lrck_s, dat_s;
  assign bit_tick = pin_rise[0];
  assign lrck_s   = pin_s[1];
  assign dat_s    = pin_s[2];

  rx_state_t         state_q;
  logic              ch_q, lr_prev_q, left_ok_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-2:0] sh_q;
  logic [DATA_W-1:0] left_hold_q;

  logic              lr_edge, last_bit, commit;
  logic [DATA_W-1:0] word;

  assign lr_edge  = bit_tick && (lrck_s != lr_prev_q);
  assign last_bit = (cnt_q == CW'(DATA_W-1));
  assign word     = {sh_q, dat_s};
  assign commit   = enable && bit_tick && !lr_edge && (state_q == SHIFT) &&
                    last_bit && (ch_q == CH_RIGHT) && left_ok_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= CH_LEFT;
      cnt_q       <= '0;
      sh_q        <= '0;
      lr_prev_q   <= 1'b0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
    end else begin
      if (bit_tick) lr_prev_q <= lrck_s;
      if (!enable) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        sh_q      <= '0;
        left_ok_q <= 1'b0;
      end else if (bit_tick) begin
        case (state_q)
          IDLE: if (lr_edge && lrck_s == CH_LEFT) begin
            state_q <= SHIFT;
            ch_q    <= CH_LEFT;
            cnt_q   <= '0;
            sh_q    <= '0;
          end
          SHIFT: if (lr_edge) begin
            // Short word: drop it and poison the pending pair.
            ch_q      <= lrck_s;
            cnt_q     <= '0;
            sh_q      <= '0;
            left_ok_q <= 1'b0;
          end else begin
            sh_q  <= word[DATA_W-2:0];
            cnt_q <= cnt_q + CW'(1);
            if (last_bit) begin
              state_q <= WAIT;
              if (ch_q == CH_LEFT) begin
                left_hold_q <= word;
                left_ok_q   <= 1'b1;
              end else begin
                left_ok_q   <= 1'b0;
              end
            end
          end
          WAIT: if (lr_edge) begin
            state_q <= SHIFT;
            ch_q    <= lrck_s;
            cnt_q   <= '0;
            sh_q    <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  function automatic logic [PW-1:0] mag(input logic [DATA_W-1:0] s);
    if (!s[DATA_W-1])         return s[PW-1:0];
    if (s[PW-1:0] == '0)      return '1;
    return ~s[PW-1:0] + PW'(1);
  endfunction

  logic [PW-1:0] mag_l, mag_r, mag_max, peak_dec;
  assign mag_l    = mag(left_hold_q);
  assign mag_r    = mag(word);
  assign mag_max  = (mag_l > mag_r) ? mag_l : mag_r;
  assign peak_dec = peak - (peak >> DECAY_SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      peak         <= '0;
    end else begin
      if (commit) begin
        sample_left  <= left_hold_q;
        sample_right <= word;
        sample_valid <= 1'b1;
        peak         <= (mag_max > peak) ? mag_max : peak_dec;
      end else if (!enable || (sample_valid && sample_ready)) begin
        sample_valid <= 1'b0;
      end
      if (commit && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (clear_overrun)                      overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2s_audio_rx.sv
// Directed bench for i2s_audio_rx: codec-side bit stream driven from tasks, checks via assertions.
module tb_i2s_audio_rx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        bclk = 1'b0, lrck = 1'b0, dat = 1'b0;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid, sample_ready = 1'b0;
  logic        overrun, clear_overrun = 1'b0;
  logic [14:0] peak;

  int checks = 0;
  int passes = 0;
  int acc_cnt = 0;
  logic [15:0] acc_l = '0, acc_r = '0;

  always #5 clk = ~clk;

  i2s_audio_rx dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .aud_bclk     (bclk),
    .aud_adclrck  (lrck),
    .aud_adcdat   (dat),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .clear_overrun(clear_overrun),
    .peak         (peak)
  );

  always @(posedge clk) begin
    if (sample_valid && sample_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_l   <= sample_left;
      acc_r   <= sample_right;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One BCLK period: 4 clk low (data/LRCK change), 4 clk high.
  task automatic send_bit(input logic lr, input logic d);
    @(negedge clk); bclk = 1'b0; lrck = lr; dat = d;
    repeat (3) @(negedge clk);
    @(negedge clk); bclk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Slot bit 0 is the I2S delay bit, bits 1..16 carry the word MSB first.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++)
      send_bit(lr, (i >= 1 && i <= 16) ? w[16-i] : 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " left"},    32'(sample_left),  32'h0);
    check({tag, " right"},   32'(sample_right), 32'h0);
    check({tag, " valid"},   32'(sample_valid), 32'h0);
    check({tag, " overrun"}, 32'(overrun),      32'h0);
    check({tag, " peak"},    32'(peak),         32'h0);
  endtask

  int n0;
  logic [15:0] wb_r;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    enable = 1'b1;
    sample_ready = 1'b1;

    // Basic pair, ready held high
    n0 = acc_cnt;
    send_slot(1'b1, 16'h0, 4);
    send_frame(16'h1234, 16'hABCD);
    check("t1 accepts", 32'(acc_cnt), 32'(n0 + 1));
    check("t1 left",    32'(acc_l),   32'h1234);
    check("t1 right",   32'(acc_r),   32'hABCD);
    check("t1 peak",    32'(peak),    32'h5433);
    check("t1 overrun", 32'(overrun), 32'h0);

    // Overrun: two unaccepted frames
    sample_ready = 1'b0;
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    check("t2 valid",   32'(sample_valid), 32'h1);
    check("t2 left",    32'(sample_left),  32'h3333);
    check("t2 right",   32'(sample_right), 32'h4444);
    check("t2 overrun", 32'(overrun),      32'h1);
    check("t2 peak",    32'(peak),         32'h4A01);
    @(negedge clk); clear_overrun = 1'b1;
    @(negedge clk); clear_overrun = 1'b0;
    check("t2 ovr clr",  32'(overrun),      32'h0);
    check("t2 valid hold", 32'(sample_valid), 32'h1);
    sample_ready = 1'b1;
    @(negedge clk);
    check("t2 accepted", 32'(sample_valid), 32'h0);

    // Short right word drops the frame
    n0 = acc_cnt;
    send_slot(1'b0, 16'h5555, 32);
    send_slot(1'b1, 16'h6666, 11);
    send_slot(1'b0, 16'h0001, 32);
    check("t3 no pair", 32'(acc_cnt), 32'(n0));
    send_slot(1'b1, 16'h0002, 32);
    check("t3 accepts", 32'(acc_cnt), 32'(n0 + 1));
    check("t3 left",    32'(acc_l),   32'h0001);
    check("t3 right",   32'(acc_r),   32'h0002);
    check("t3 peak",    32'(peak),    32'h4561);

    // Reset mid left word
    send_slot(1'b0, 16'h7777, 9);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t4 rst");
    reset = 1'b0;
    n0 = acc_cnt;
    send_slot(1'b0, 16'h0, 23);
    send_slot(1'b1, 16'h8888, 32);
    check("t4 no pair", 32'(acc_cnt), 32'(n0));
    send_frame(16'h0ABC, 16'h0DEF);
    check("t4 accepts", 32'(acc_cnt), 32'(n0 + 1));
    check("t4 left",    32'(acc_l),   32'h0ABC);
    check("t4 right",   32'(acc_r),   32'h0DEF);
    check("t4 peak",    32'(peak),    32'h0DEF);

    // Most-negative saturation and decay
    send_frame(16'h8000, 16'h0000);
    check("t5 peak sat", 32'(peak), 32'h7FFF);
    send_frame(16'h0000, 16'h0000);
    check("t5 peak dec", 32'(peak), 32'h7800);

    // Commit coincides with accept
    sample_ready = 1'b0;
    send_frame(16'h0102, 16'h0304);
    check("t6 valid A", 32'(sample_valid), 32'h1);
    wb_r = 16'h0708;
    send_slot(1'b0, 16'h0506, 32);
    send_slot(1'b1, wb_r, 16);
    @(negedge clk); bclk = 1'b0; dat = wb_r[0];
    repeat (3) @(negedge clk);
    @(negedge clk); bclk = 1'b1;
    // The LSB tick is acted on at the third rising clk after the pin edge.
    @(negedge clk);
    @(negedge clk); sample_ready = 1'b1;
    @(negedge clk); sample_ready = 1'b0;
    @(negedge clk);
    check("t6 valid",   32'(sample_valid), 32'h1);
    check("t6 left",    32'(sample_left),  32'h0506);
    check("t6 right",   32'(sample_right), 32'h0708);
    check("t6 overrun", 32'(overrun),      32'h0);
    check("t6 peak",    32'(peak),         32'h6978);

    // Disable clears valid, holds data
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    check("en valid", 32'(sample_valid), 32'h0);
    check("en left",  32'(sample_left),  32'h0506);
    check("en peak",  32'(peak),         32'h6978);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
